imem_responder: RTL and testbench

Instruction-memory responder on the far end of the fetch interface; the program counter side is the requester.
- Accepts word-aligned fetch addresses over a valid/ready request channel.
- Reads a synchronous instruction array and returns the instruction words in order over a valid/ready response channel.
- Holds responses in a small buffer so fetch stalls do not drop data.
- Flush input discards stale responses on branch redirect.
- Side write port loads the program.

---
 rtl/imem_responder_pkg.sv | 12 +
 rtl/imem_resp_fifo.sv | 55 +++++
 rtl/imem_responder.sv | 91 +++++++++
 tb/tb_imem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants for the instruction-memory responder.
// The default word width may be overridden through the WORDSIZE parameter.
package imem_responder_pkg;
    localparam int WORDSIZE_DEF   = 32;
    localparam int DEPTH_LOG2_DEF = 10;
    localparam int RESP_DEPTH_DEF = 2;

    // log2 of bytes per word: the byte-address to word-index shift
    function automatic int word_shift(input int wordsize);
        return $clog2(wordsize / 8);
    endfunction
endpackage

// File: rtl/imem_resp_fifo.sv
// Small response FIFO with flush; entries are {err, addr, data}.
// Head reads as zero while empty so idle outputs stay clean.
module imem_resp_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_data,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_count;
    logic          w_push, w_pop;

    assign w_pop   = i_pop && (r_count != '0) && !i_flush;
    assign w_push  = i_push && !i_flush;
    assign o_count = r_count;
    assign o_data  = (r_count != '0) ? r_mem[r_rd] : '0;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop)  r_rd <= nxt(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: registered array read, one read in flight, in-order response FIFO.
// Define IMEM_ERR_EN to flag misaligned / out-of-range fetches instead of wrapping.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int WORDSIZE   = WORDSIZE_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WORDSIZE-1:0] req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORDSIZE-1:0] resp_data,
    output logic [WORDSIZE-1:0] resp_addr,
    output logic                resp_err,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [WORDSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0] wr_data
);
    localparam int SHIFT  = word_shift(WORDSIZE);
    localparam int NWORDS = 1 << DEPTH_LOG2;
    localparam int FW     = 2 * WORDSIZE + 1;
    localparam int CW     = $clog2(RESP_DEPTH + 1);

    logic [WORDSIZE-1:0]   r_mem [NWORDS];
    logic [WORDSIZE-1:0]   r_rd_data;
    logic [WORDSIZE-1:0]   r_inf_addr;
    logic                  r_inf, r_inf_err;
    logic [DEPTH_LOG2-1:0] w_idx, w_wr_idx;
    logic                  w_err, w_accept, w_wr_ok;
    logic [CW-1:0]         w_count;
    logic [FW-1:0]         w_push_data, w_head;

    assign w_idx    = req_addr[SHIFT +: DEPTH_LOG2];
    assign w_wr_idx = wr_addr[SHIFT +: DEPTH_LOG2];
    assign w_wr_ok  = wr_en && ((wr_addr >> (SHIFT + DEPTH_LOG2)) == '0);

`ifdef IMEM_ERR_EN
    assign w_err = ((req_addr & WORDSIZE'((1 << SHIFT) - 1)) != '0) ||
                   ((req_addr >> (SHIFT + DEPTH_LOG2)) != '0);
`else
    assign w_err = 1'b0;
`endif

    // Slots are reserved for the in-flight read, so a same-cycle pop never opens the door early
    assign req_ready = (int'(w_count) + int'(r_inf)) < RESP_DEPTH;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge CLK) begin
        if (w_wr_ok) r_mem[w_wr_idx] <= wr_data;
        if (w_accept && !w_err) r_rd_data <= r_mem[w_idx];
    end

    // A request taken on a flush edge replaces whatever was in flight
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_inf      <= 1'b0;
            r_inf_err  <= 1'b0;
            r_inf_addr <= '0;
        end else begin
            r_inf <= w_accept;
            if (w_accept) begin
                r_inf_err  <= w_err;
                r_inf_addr <= req_addr;
            end
        end
    end

    assign w_push_data = {r_inf_err, r_inf_addr, r_inf_err ? '0 : r_rd_data};

    imem_resp_fifo #(.W(FW), .DEPTH(RESP_DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset   (reset),
        .i_push  (r_inf),
        .i_pop   (resp_valid && resp_ready),
        .i_flush (flush),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign resp_valid = (w_count != '0);
    assign resp_err   = w_head[FW-1];
    assign resp_addr  = w_head[FW-2 -: WORDSIZE];
    assign resp_data  = w_head[WORDSIZE-1:0];
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder; expectations follow IMEM_ERR_EN when defined.
module tb_imem_responder;
    localparam int W  = 32;
    localparam int DL = 10;
    localparam int RD = 2;
    localparam int NW = 1 << DL;

    logic         CLK = 1'b0, reset = 1'b1;
    logic         req_valid = 1'b0, resp_ready = 1'b0, flush = 1'b0, wr_en = 1'b0;
    logic [W-1:0] req_addr = '0, wr_addr = '0, wr_data = '0;
    logic         req_ready, resp_valid, resp_err;
    logic [W-1:0] resp_data, resp_addr;

    always #5 CLK = ~CLK;

    imem_responder #(.WORDSIZE(W), .DEPTH_LOG2(DL), .RESP_DEPTH(RD)) dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
        .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int           n_chk = 0, n_err = 0, n_resp = 0;
    logic [W-1:0] model [NW];
    logic [2*W:0] sb [$];

    task automatic chk(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] exp_of(input logic [W-1:0] a);
        logic [W-1:0] idx;
        idx = a >> 2;
`ifdef IMEM_ERR_EN
        if (a[1:0] != 2'b00 || idx >= NW) return {1'b1, a, {W{1'b0}}};
`endif
        return {1'b0, a, model[idx[DL-1:0]]};
    endfunction

    always @(negedge CLK) begin
        if (!reset && resp_valid && resp_ready) begin
            n_resp++;
            if (sb.size() == 0) chk("spurious_resp", {{(2*W){1'b0}}, resp_valid}, '0);
            else chk("resp", {resp_err, resp_addr, resp_data}, sb.pop_front());
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic req(input logic [W-1:0] a);
        int b;
        req_valid = 1'b1;
        req_addr  = a;
        b = 0;
        while (!req_ready && b < 50) begin
            cyc();
            b++;
        end
        if (!req_ready) chk("req_timeout", {{(2*W){1'b0}}, req_ready}, 1);
        else sb.push_back(exp_of(a));
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
        if ((a >> 2) < NW) model[a[DL+1:2]] = d;
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        while ((sb.size() != 0 || resp_valid) && b < 100) begin
            cyc();
            b++;
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        int r0;
        repeat (2) cyc();
        chk("rst_valid", {{(2*W){1'b0}}, resp_valid}, 0);
        chk("rst_head", {resp_err, resp_addr, resp_data}, '0);
        reset = 1'b0;
        cyc();
        chk("rst_ready", {{(2*W){1'b0}}, req_ready}, 1);

        load(32'h0, 32'h1111_1111);
        load(32'h4, 32'h2222_2222);
        load(32'h9, 32'h3333_3333);     // misaligned write lands on word 2
        load(32'h1000, 32'h5555_5555);  // out of range, must not touch word 0

        // back-to-back fetch and latency
        resp_ready = 1'b1;
        req(32'h0);
        chk("lat_inflight", {{(2*W){1'b0}}, resp_valid}, 0);
        req(32'h4);
        chk("lat_valid", {{(2*W){1'b0}}, resp_valid}, 1);
        chk("lat_data", {{(W+1){1'b0}}, resp_data}, 32'h1111_1111);
        drain("drain_b2b");

        // backpressure: third request held until space frees
        resp_ready = 1'b0;
        r0 = n_resp;
        req(32'h8);
        req(32'h0);
        req_valid = 1'b1; req_addr = 32'h4;
        chk("full_ready0", {{(2*W){1'b0}}, req_ready}, 0);
        cyc();
        chk("full_ready1", {{(2*W){1'b0}}, req_ready}, 0);
        resp_ready = 1'b1;
        req(32'h4);
        drain("drain_full");
        chk("full_count", n_resp - r0, 3);

        // flush with nothing new: queue vanishes
        resp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        cyc();
        flush = 1'b1;
        sb.delete();
        cyc();
        flush = 1'b0;
        chk("flush_drop", {{(2*W){1'b0}}, resp_valid}, 0);
        repeat (2) cyc();
        chk("flush_stay", {{(2*W){1'b0}}, resp_valid}, 0);

        // flush with a same-cycle request: only that one survives
        req(32'h0);
        cyc();
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
        chk("flush_ready", {{(2*W){1'b0}}, req_ready}, 1);
        sb.delete();
        sb.push_back(exp_of(32'h8));
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        cyc();
        chk("flush_kept", {{(2*W){1'b0}}, resp_valid}, 1);
        chk("flush_addr", {{(W+1){1'b0}}, resp_addr}, 32'h8);
        resp_ready = 1'b1;
        drain("drain_flush");

        // read-before-write on the same word
        wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'hDEAD_BEEF;
        req(32'h4);
        wr_en = 1'b0;
        model[1] = 32'hDEAD_BEEF;
        req(32'h4);
        drain("drain_rbw");

        // misaligned and out-of-range fetches
        req(32'h2);
        req(32'h1000);
        drain("drain_err");

        // asynchronous reset with responses queued
        resp_ready = 1'b0;
        req(32'h0);
        req(32'h4);
        cyc();
        chk("pre_rst_valid", {{(2*W){1'b0}}, resp_valid}, 1);
        #2 reset = 1'b1;
        #1 chk("rst_async", {{(2*W){1'b0}}, resp_valid}, 0);
        sb.delete();
        repeat (2) cyc();
        reset = 1'b0;
        resp_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_no_stale", {{(2*W){1'b0}}, resp_valid}, 0);
        req(32'h4);
        req(32'h0);
        drain("drain_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end
endmodule
